// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter for the data memory on the req/gnt/rvalid bus.
// Optional macro ARB_STATS_EN enables the saturating contention counter on conflict_cnt.
module data_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                HCLK,
  input  logic                RSTn,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_be,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_gnt,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [15:0]         conflict_cnt
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t            state, state_nxt;
  logic                   locked_id;
  logic                   rr_ptr;
  logic                   sel;
  logic                   sel_valid;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   head_id;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OUTSTANDING-1:0] fifo_mem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count == CNT_W'(OUTSTANDING));
  assign fifo_empty = (count == '0);

  // A stalled request keeps the slave port on the same master until it is accepted.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (state == LOCKED) begin
      sel       = locked_id;
      sel_valid = 1'b1;
    end else if (m0_req && m1_req) begin
      sel       = rr_ptr;
      sel_valid = 1'b1;
    end else if (m0_req) begin
      sel       = 1'b0;
      sel_valid = 1'b1;
    end else if (m1_req) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end
  end

  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    s_be    = '0;
    s_wdata = '0;
    if (sel_valid) begin
      if (sel) begin
        s_addr  = m1_addr;
        s_we    = m1_we;
        s_be    = m1_be;
        s_wdata = m1_wdata;
      end else begin
        s_addr  = m0_addr;
        s_we    = m0_we;
        s_be    = m0_be;
        s_wdata = m0_wdata;
      end
    end
  end

  assign s_req  = (m0_req | m1_req) & ~fifo_full;
  assign accept = s_req & s_gnt;
  assign m0_gnt = accept & sel_valid & ~sel;
  assign m1_gnt = accept & sel_valid & sel;

  assign push      = accept;
  assign pop       = s_rvalid & ~fifo_empty;
  assign head_id   = fifo_mem[rd_ptr];
  assign m0_rvalid = pop & ~head_id;
  assign m1_rvalid = pop & head_id;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (s_req && !s_gnt) state_nxt = LOCKED;
      LOCKED:   if (s_req && s_gnt)  state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      locked_id <= 1'b0;
    end else if (state == UNLOCKED && s_req && !s_gnt) begin
      locked_id <= sel;
    end
  end

  // The master just granted drops to lowest priority for the next contention.
  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~sel;
    end
  end

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sel;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      conflict_q <= 16'h0000;
    end else if (m0_req && m1_req && state == UNLOCKED && conflict_q != 16'hFFFF) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed vectors push expected grants/responses,
// a negedge monitor pops and compares them whenever the DUT presents a grant or rvalid.
module tb_data_mem_arbiter;

  logic        HCLK;
  logic        RSTn;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [15:0] conflict_cnt;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } resp_t;

  gnt_t  gnt_q[$];
  resp_t resp_q[$];
  int    checks;
  int    passed;

`ifdef ARB_STATS_EN
  localparam logic [15:0] EXP_CONF5 = 16'd5;
`else
  localparam logic [15:0] EXP_CONF5 = 16'd0;
`endif

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTSTANDING(2)) dut (
    .HCLK(HCLK), .RSTn(RSTn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic r0, input logic r1, input logic gnt,
                                input logic rv, input logic [31:0] rdata);
    m0_req   = r0;
    m1_req   = r1;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rdata;
  endtask

  task automatic expect_grant(input logic id, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    gnt_q.push_back('{id: id, addr: addr, we: we, wdata: wdata});
  endtask

  task automatic expect_resp(input logic id, input logic [31:0] data);
    resp_q.push_back('{id: id, data: data});
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check_output("rst_s_req", 32'(s_req), 32'd0);
    check_output("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check_output("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    check_output("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    check_output("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    check_output("rst_pending_grants", 32'(gnt_q.size()), 32'd0);
    check_output("rst_pending_resps", 32'(resp_q.size()), 32'd0);
    RSTn = 1'b1;
    tick();
  endtask

  // Monitor: every grant or response the DUT shows must match the head of its queue.
  initial begin
    gnt_t  g;
    resp_t r;
    forever begin
      @(negedge HCLK);
      if (RSTn) begin
        if (m0_gnt || m1_gnt) begin
          check_output("single_grant", 32'(m0_gnt & m1_gnt), 32'd0);
          check_output("grant_expected", 32'(gnt_q.size() != 0), 32'd1);
          if (gnt_q.size() != 0) begin
            g = gnt_q.pop_front();
            check_output("grant_id", 32'(m1_gnt), 32'(g.id));
            check_output("grant_addr", s_addr, g.addr);
            check_output("grant_we_wdata", s_we ? s_wdata : 32'hFFFF_FFFF, g.we ? g.wdata : 32'hFFFF_FFFF);
          end
        end
        if (m0_rvalid || m1_rvalid) begin
          check_output("single_rvalid", 32'(m0_rvalid & m1_rvalid), 32'd0);
          check_output("resp_expected", 32'(resp_q.size() != 0), 32'd1);
          if (resp_q.size() != 0) begin
            r = resp_q.pop_front();
            check_output("resp_id", 32'(m1_rvalid), 32'(r.id));
            check_output("resp_data", m1_rvalid ? m1_rdata : m0_rdata, r.data);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    passed = 0;
    RSTn = 1'b0;
    m0_addr = '0; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = '0;
    m1_addr = '0; m1_we = 1'b0; m1_be = 4'hF; m1_wdata = '0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Single read by m0 with immediate grant and next-cycle response.
    do_reset();
    m0_addr = 32'h0010_0004;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_grant(1'b0, 32'h0010_0004, 1'b0, 32'h0);
    expect_resp(1'b0, 32'hDEAD_BEEF);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #2;
    check_output("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check_output("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Continuous contention alternates m0,m1,m0,m1; m1 issues writes.
    do_reset();
    m0_addr = 32'h0010_0100;
    m1_addr = 32'h0020_0200; m1_we = 1'b1; m1_wdata = 32'hCAFE_0001;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(k < 4, k < 4, 1'b1, k > 0, 32'hA000_0000 + 32'(k - 1));
      if (k < 4) begin
        if (k % 2 == 0) expect_grant(1'b0, 32'h0010_0100, 1'b0, 32'h0);
        else            expect_grant(1'b1, 32'h0020_0200, 1'b1, 32'hCAFE_0001);
        expect_resp(1'(k % 2), 32'hA000_0000 + 32'(k));
      end
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    m1_we = 1'b0;
    tick();

    // Stalled m0 request stays locked on the slave port while m1 waits.
    do_reset();
    m0_addr = 32'h0010_0010;
    m1_addr = 32'h0020_0020;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, k > 0, k == 3, 1'b0, 32'h0);
      if (k == 3) expect_grant(1'b0, 32'h0010_0010, 1'b0, 32'h0);
      #2;
      check_output("t3_locked_addr", s_addr, 32'h0010_0010);
      check_output("t3_s_req", 32'(s_req), 32'd1);
      tick();
    end
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_0000);
    expect_grant(1'b1, 32'h0020_0020, 1'b0, 32'h0);
    expect_resp(1'b0, 32'h1111_0000);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_0000);
    expect_resp(1'b1, 32'h2222_0000);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Two outstanding fill the FIFO; a third request waits for a response.
    do_reset();
    m0_addr = 32'h0010_0040;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_grant(1'b0, 32'h0010_0040, 1'b0, 32'h0);
    tick();
    m0_addr = 32'h0010_0044;
    expect_grant(1'b0, 32'h0010_0044, 1'b0, 32'h0);
    tick();
    m0_addr = 32'h0010_0048;
    #2;
    check_output("t4_full_s_req_a", 32'(s_req), 32'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h3333_0000);
    expect_resp(1'b0, 32'h3333_0000);
    #2;
    check_output("t4_full_s_req_b", 32'(s_req), 32'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_grant(1'b0, 32'h0010_0048, 1'b0, 32'h0);
    #2;
    check_output("t4_reenabled_s_req", 32'(s_req), 32'd1);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_0001);
    expect_resp(1'b0, 32'h3333_0001);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_0002);
    expect_resp(1'b0, 32'h3333_0002);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Reset with one transfer outstanding; stray response ignored, rr_ptr back to m0.
    do_reset();
    m0_addr = 32'h0010_0030;
    m1_addr = 32'h0020_0030;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_grant(1'b0, 32'h0010_0030, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    #2;
    check_output("t5_stray_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expect_grant(1'b0, 32'h0010_0030, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    expect_grant(1'b1, 32'h0020_0030, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Five unlocked contention cycles for the statistics counter.
    do_reset();
    m0_addr = 32'h0010_0050;
    m1_addr = 32'h0020_0050;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, k > 0, 32'h5000_0000 + 32'(k - 1));
      expect_grant(1'(k % 2), (k % 2 == 0) ? 32'h0010_0050 : 32'h0020_0050, 1'b0, 32'h0);
      expect_resp(1'(k % 2), 32'h5000_0000 + 32'(k));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h5000_0004);
    #2;
    check_output("t6_conflict_cnt", 32'(conflict_cnt), 32'(EXP_CONF5));
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

`ifdef ARB_STATS_EN
    // Long contention run drives the counter into saturation.
    do_reset();
    for (int k = 0; k < 65540; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, k > 0, 32'(k - 1));
      expect_grant(1'(k % 2), (k % 2 == 0) ? 32'h0010_0050 : 32'h0020_0050, 1'b0, 32'h0);
      expect_resp(1'(k % 2), 32'(k));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'(65539));
    #2;
    check_output("t6_conflict_saturated", 32'(conflict_cnt), 32'h0000_FFFF);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
`endif

    tick();
    check_output("end_pending_grants", 32'(gnt_q.size()), 32'd0);
    check_output("end_pending_resps", 32'(resp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
